// File: rtl/text_loader_if.sv
// Byte-stream input and Text-memory write port of the boot loader.
// The master drives the byte stream; the slave (the loader) returns
// in_ready, drives the memory write port and reports load status.
interface text_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] w_addr;
    logic              w_en;
    logic [31:0]       w_data;
    logic              core_rst;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, w_addr, w_en, w_data, core_rst, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, w_addr, w_en, w_data, core_rst, done, err
    );
endinterface

// File: rtl/text_loader.sv
// Boot-time Text memory writer. Stream format: 16-bit word count N (MSB
// first) followed by N big-endian 32-bit words. Each assembled word is
// written with a one-cycle w_en pulse at consecutive word addresses from 0.
// The core is held in reset until all N words are written; a count larger
// than DEPTH parks the loader in an error state with the core still in reset.
module text_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    text_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_wen;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic              r_core_rst;

    logic              w_fire;
    logic [15:0]       w_len_rx;
    logic              w_last;

    // A byte moves only when offered and the registered ready is high.
    assign w_fire   = bus.in_valid & r_ready;
    // Full count as it appears while the low count byte is on the bus.
    assign w_len_rx = {r_len_hi, bus.in_data};
    // The word being written is the final one of the image (N >= 1 here).
    assign w_last   = (r_addr == ADDR_W'(r_len - 16'd1));

    assign bus.in_ready = r_ready;
    assign bus.w_addr   = r_addr;
    assign bus.w_en     = r_wen;
    assign bus.w_data   = r_data;
    assign bus.core_rst = r_core_rst;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

    // Loader FSM; every output is registered and set together with the
    // state it belongs to, so ready/done/core_rst change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LEN_HI;
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_bcnt     <= 2'd0;
            r_addr     <= '0;
            r_data     <= 32'd0;
            r_wen      <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_LEN_HI: begin
                    // Ready rises on the first edge after reset is released.
                    r_ready <= 1'b1;
                    if (w_fire) begin
                        r_len_hi <= bus.in_data;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_fire) begin
                        r_len <= w_len_rx;
                        if (w_len_rx == 16'd0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                            r_ready    <= 1'b0;
                        end else if (32'(w_len_rx) > 32'(DEPTH)) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    if (w_fire) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_state <= S_WRITE;
                            r_wen   <= 1'b1;
                            r_data  <= {r_shift, bus.in_data};
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    // Address stays on the last word so it never exceeds N-1.
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_WORD;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                end
                S_ERR: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_LEN_HI;
                end
            endcase
        end
    end

    // Byte assembly; the first three bytes of a word collect here and the
    // fourth is appended straight from the bus when the word is committed.
    always_ff @(posedge clk) begin
        if (r_state == S_WORD && w_fire) begin
            r_shift <= {r_shift[15:0], bus.in_data};
        end
    end
endmodule
